riscv_mem: RTL and testbench

Memory-access stage of the RISC-V pipeline, directly downstream of the execute stage. It takes the ALU result, destination register and load/store control from execute and performs the data-memory access over a req/ack handshake. It formats load data (byte-lane steering, sign/zero extension) and presents a registered write-back record to the register file. Non-memory operations pass through with one cycle of latency; memory operations stall the upstream stage until the memory acknowledges.

---
 rtl/riscv_mem_pkg.sv | 16 +
 rtl/riscv_mem_align.sv | 57 +++++
 rtl/riscv_mem.sv | 135 +++++++++++++
 tb/tb_riscv_mem.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants for the RISC-V memory-access stage: load/store funct3 codes and FSM states.
package riscv_mem_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

endpackage

// File: rtl/riscv_mem_align.sv
// Byte-lane steering for loads and stores: byte enables, store replication, load extension, alignment check.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module riscv_mem_align
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic              store,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    localparam int BW = XLEN / 8;

    logic            is_byte;
    logic            is_half;
    logic [XLEN-1:0] lane;

    // Unsigned encodings only exist for loads; a store with those codes is a word access.
    assign is_byte = (funct3 == FUNCT3_SB) || (!store && funct3 == FUNCT3_LBU);
    assign is_half = (funct3 == FUNCT3_SH) || (!store && funct3 == FUNCT3_LHU);
    assign lane    = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be         = '1;
        wdata      = store_data;
        misaligned = 1'b0;
        if (is_byte) begin
            be    = BW'(1) << addr_lo;
            wdata = {BW{store_data[7:0]}};
        end else if (is_half) begin
            be         = BW'(3) << addr_lo;
            wdata      = {(BW/2){store_data[15:0]}};
            misaligned = addr_lo[0];
        end else begin
            misaligned = (addr_lo != 2'b00);
        end
    end

    always_comb begin
        case (funct3)
            FUNCT3_LB:  load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            FUNCT3_LH:  load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
            FUNCT3_LBU: load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            FUNCT3_LHU: load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
            default:    load_data = lane;
        endcase
    end

endmodule

// File: rtl/riscv_mem.sv
// Memory-access pipeline stage: performs load/store over req/ack and registers the write-back record.
// Latency: ALU ops and faults 1 cycle; memory ops 1 cycle after dmem_ack (minimum 2 from accept).
// Backpressure: in_ready low from accept of a memory op until the cycle after its ack.
module riscv_mem
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGN = 32,
    parameter int REGA = $clog2(REGN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [REGA-1:0]   rdi,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REGA-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misaligned
);

    logic [0:0]        state;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_addr_lo;
    logic [REGA-1:0]   lat_rd;
    logic              lat_load;

    logic              acc;
    logic [2:0]        al_funct3;
    logic [1:0]        al_addr_lo;
    logic              al_store;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_load;
    logic              al_mis;

    assign in_ready = (state == ST_IDLE);
    assign acc      = (state == ST_ACCESS);

    // One aligner serves both phases: live inputs decide the request in IDLE,
    // latched fields format the returning load data in ACCESS.
    assign al_funct3  = acc ? lat_funct3  : funct3;
    assign al_addr_lo = acc ? lat_addr_lo : alu_result[1:0];
    assign al_store   = acc ? 1'b0        : store;

    riscv_mem_align #(.XLEN(XLEN)) u_align (
        .funct3     (al_funct3),
        .store      (al_store),
        .addr_lo    (al_addr_lo),
        .store_data (store_data),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_funct3  <= '0;
            lat_addr_lo <= '0;
            lat_rd      <= '0;
            lat_load    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            misaligned  <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        lat_funct3  <= funct3;
                        lat_addr_lo <= alu_result[1:0];
                        lat_rd      <= rdi;
                        lat_load    <= load;
                        if (!load && !store) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (rdi != '0);
                            wb_rd    <= rdi;
                            wb_data  <= alu_result;
                        end else if (al_mis) begin
                            // Faulting address is reported in wb_data for the trap handler.
                            wb_valid   <= 1'b1;
                            wb_we      <= 1'b0;
                            wb_rd      <= rdi;
                            wb_data    <= alu_result;
                            misaligned <= 1'b1;
                        end else begin
                            state      <= ST_ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= store;
                            dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                            dmem_be    <= al_be;
                            dmem_wdata <= al_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state    <= ST_IDLE;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= lat_load && (lat_rd != '0);
                        wb_rd    <= lat_rd;
                        wb_data  <= lat_load ? al_load : '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: directed scenarios then randomized ops against a behavioural model.
module tb_riscv_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, load, store;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rdi, wb_rd;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_we, misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_mem dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .rdi        (rdi),
        .load       (load),
        .store      (store),
        .funct3     (funct3),
        .store_data (store_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misaligned (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: access size from funct3, lanes and extension by plain arithmetic.
    function automatic void model(input logic [2:0] f3, input logic ld, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rdat,
                                  output logic mis, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] lv);
        int size;
        int off;
        logic [31:0] w;
        off = int'(addr[1:0]);
        if (f3 == 3'd0 || (ld && f3 == 3'd4))      size = 1;
        else if (f3 == 3'd1 || (ld && f3 == 3'd5)) size = 2;
        else                                       size = 4;
        mis = (off % size) != 0;
        be  = (size == 4) ? 4'hF : 4'((size == 1 ? 1 : 3) << off);
        wd  = (size == 1) ? (sd & 32'hFF) * 32'h01010101 :
              (size == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
        w   = rdat >> (8 * off);
        case (f3)
            3'd0:    lv = (w & 32'hFF)   | (((w & 32'h80) != 0)   ? 32'hFFFFFF00 : 32'h0);
            3'd1:    lv = (w & 32'hFFFF) | (((w & 32'h8000) != 0) ? 32'hFFFF0000 : 32'h0);
            3'd4:    lv = w & 32'hFF;
            3'd5:    lv = w & 32'hFFFF;
            default: lv = rdat;
        endcase
    endfunction

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdat,
                          input logic [4:0] rd, input int delay);
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd, lv;
        model(f3, ld, addr, sd, rdat, mis, be, wd, lv);
        chk("ready_before", in_ready, 1);
        in_valid = 1; load = ld; store = st; funct3 = f3;
        alu_result = addr; store_data = sd; rdi = rd;
        tick();
        in_valid = 0; load = 0; store = 0;
        funct3 = 3'($urandom); alu_result = $urandom; store_data = $urandom; rdi = 5'($urandom);
        if (!ld && !st) begin
            chk("alu_wb_valid", wb_valid, 1);
            chk("alu_wb_we", wb_we, rd != 0);
            chk("alu_wb_rd", wb_rd, rd);
            chk("alu_wb_data", wb_data, addr);
            chk("alu_mis", misaligned, 0);
            chk("alu_req", dmem_req, 0);
            chk("alu_ready", in_ready, 1);
        end else if (mis) begin
            chk("mis_wb_valid", wb_valid, 1);
            chk("mis_wb_we", wb_we, 0);
            chk("mis_flag", misaligned, 1);
            chk("mis_req", dmem_req, 0);
            chk("mis_ready", in_ready, 1);
        end else begin
            chk("mem_req", dmem_req, 1);
            chk("mem_we", dmem_we, st);
            chk("mem_addr", dmem_addr, addr & 32'hFFFFFFFC);
            chk("mem_be", dmem_be, be);
            chk("mem_ready_low", in_ready, 0);
            chk("mem_wb_quiet", wb_valid, 0);
            if (st) chk("mem_wdata", dmem_wdata, wd);
            for (int i = 0; i < delay; i++) begin
                tick();
                chk("hold_req", dmem_req, 1);
                chk("hold_ready_low", in_ready, 0);
                chk("hold_addr", dmem_addr, addr & 32'hFFFFFFFC);
            end
            dmem_ack = 1; dmem_rdata = rdat;
            tick();
            dmem_ack = 0; dmem_rdata = $urandom;
            chk("ack_wb_valid", wb_valid, 1);
            chk("ack_wb_we", wb_we, ld && rd != 0);
            chk("ack_wb_rd", wb_rd, rd);
            chk("ack_req_drop", dmem_req, 0);
            chk("ack_ready", in_ready, 1);
            chk("ack_mis", misaligned, 0);
            if (ld) chk("load_data", wb_data, lv);
        end
    endtask

    task automatic idle_cycle();
        tick();
        chk("idle_wb_valid", wb_valid, 0);
        chk("idle_mis", misaligned, 0);
        chk("idle_req", dmem_req, 0);
    endtask

    initial begin
        logic        r_ld, r_st;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          kind;

        rst = 1; in_valid = 0; load = 0; store = 0; funct3 = 0;
        alu_result = 0; store_data = 0; rdi = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mis", misaligned, 0);
        rst = 0;
        tick();

        run_op(0, 0, 3'd0, 32'h1234, 0, 0, 5'd5, 0);
        run_op(0, 0, 3'd0, 32'hCAFE, 0, 0, 5'd0, 0);
        run_op(1, 0, 3'd0, 32'h103, 0, 32'h80FFFFFF, 5'd7, 3);
        run_op(1, 0, 3'd5, 32'h102, 0, 32'hBEEF0000, 5'd9, 0);
        run_op(1, 0, 3'd5, 32'h102, 0, 32'hBEEF0000, 5'd0, 1);
        run_op(0, 1, 3'd0, 32'h101, 32'hAB, 0, 5'd3, 2);
        run_op(1, 0, 3'd2, 32'h102, 0, 0, 5'd4, 0);
        idle_cycle();

        // Reset in the middle of an access, then a stray ack.
        in_valid = 1; load = 1; store = 0; funct3 = 3'd2; alu_result = 32'h200; rdi = 5'd6;
        tick();
        in_valid = 0; load = 0;
        chk("pre_rst_req", dmem_req, 1);
        #2 rst = 1;
        #1;
        chk("midrst_req", dmem_req, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_wb_valid", wb_valid, 0);
        #2 rst = 0;
        dmem_ack = 1; dmem_rdata = 32'h12345678;
        tick();
        dmem_ack = 0;
        chk("stray_ack_wb_valid", wb_valid, 0);
        chk("stray_ack_ready", in_ready, 1);
        chk("stray_ack_req", dmem_req, 0);

        for (int n = 0; n < 80; n++) begin
            kind   = $urandom_range(0, 2);
            r_ld   = (kind == 1);
            r_st   = (kind == 2);
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            run_op(r_ld, r_st, r_f3, r_addr, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
